// File: rtl/spi_word_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_word_slave
// Brief    : SPI mode-0 slave front end. Oversamples sclk/cs_n/mosi in the clk
//            domain, deserialises each chip-select frame into one WIDTH-bit
//            word tagged KEY/DATA/CONTROL, and serialises tx_word onto miso.
// Revision : 1.0 - initial release
// ============================================================================
module spi_word_slave #(
    parameter int WIDTH       = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_word,
    input  logic             idx_clr,
    output logic [WIDTH-1:0] rx_word,
    output logic             rx_valid,
    output logic [1:0]       rx_index,
    output logic             rx_err,
    output logic             busy
);

    localparam logic       c_IDLE      = 1'b0;
    localparam logic       c_ACTIVE    = 1'b1;
    localparam logic [6:0] c_CNT_MAX   = 7'd127;
    localparam logic [6:0] c_WIDTH_CNT = 7'(WIDTH);

    // Synchroniser chains; the last stage is the first usable copy
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic                   r_mosi_d;

    logic                   w_sclk_s;
    logic                   w_cs_s;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_fall;
    logic                   w_cs_rise;

    logic                   r_state;
    logic                   w_state_nxt;
    logic                   w_frame_start;
    logic                   w_frame_stop;
    logic                   w_rx_shift;
    logic                   w_tx_shift;

    logic [WIDTH-1:0]       r_rx_sr;
    logic [WIDTH-1:0]       r_tx_sr;
    logic [6:0]             r_bit_cnt;
    logic                   r_seen_rise;
    logic                   r_end_pend;
    logic [1:0]             r_frame_idx;
    logic [1:0]             w_idx_next;

    // Pin synchronisers plus one extra registered copy used for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
            r_mosi_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
            r_mosi_d    <= r_mosi_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
    assign w_cs_fall   = ~w_cs_s   &  r_cs_d;
    assign w_cs_rise   =  w_cs_s   & ~r_cs_d;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: chip-select edges open and close a frame
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_cs_fall) w_state_nxt = c_ACTIVE;
            c_ACTIVE: if (w_cs_rise) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // FSM outputs and per-cycle datapath strobes
    always_comb begin
        busy          = (r_state == c_ACTIVE);
        miso          = (r_state == c_ACTIVE) ? r_tx_sr[WIDTH-1] : 1'b0;
        w_frame_start = (r_state == c_IDLE)   & w_cs_fall;
        w_frame_stop  = (r_state == c_ACTIVE) & w_cs_rise;
        w_rx_shift    = (r_state == c_ACTIVE) & w_sclk_rise;
        // A falling edge ahead of the first rising edge must not skip the MSB
        w_tx_shift    = (r_state == c_ACTIVE) & w_sclk_fall & r_seen_rise;
    end

    // Shift registers and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_bit_cnt   <= '0;
            r_seen_rise <= 1'b0;
        end else if (w_frame_start) begin
            r_tx_sr     <= tx_word;
            r_rx_sr     <= '0;
            r_bit_cnt   <= '0;
            r_seen_rise <= 1'b0;
        end else begin
            if (w_rx_shift) begin
                r_rx_sr     <= {r_rx_sr[WIDTH-2:0], r_mosi_d};
                r_seen_rise <= 1'b1;
                if (r_bit_cnt != c_CNT_MAX) begin
                    r_bit_cnt <= r_bit_cnt + 7'd1;
                end
            end
            if (w_tx_shift) begin
                r_tx_sr <= {r_tx_sr[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign w_idx_next = (r_frame_idx == 2'd2) ? 2'd0 : (r_frame_idx + 2'd1);

    // Frame-end evaluation one cycle after the state leaves ACTIVE; clear beats advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_end_pend  <= 1'b0;
            rx_word     <= '0;
            rx_index    <= 2'd0;
            rx_valid    <= 1'b0;
            rx_err      <= 1'b0;
            r_frame_idx <= 2'd0;
        end else begin
            r_end_pend <= w_frame_stop;
            rx_valid   <= 1'b0;
            rx_err     <= 1'b0;
            if (r_end_pend && (r_bit_cnt == c_WIDTH_CNT)) begin
                rx_word     <= r_rx_sr;
                rx_index    <= r_frame_idx;
                rx_valid    <= 1'b1;
                r_frame_idx <= idx_clr ? 2'd0 : w_idx_next;
            end else begin
                if (r_end_pend) begin
                    rx_err <= 1'b1;
                end
                if (idx_clr) begin
                    r_frame_idx <= 2'd0;
                end
            end
        end
    end

endmodule
`default_nettype wire
